// File: rtl/arith_seq.sv
// Micro-operation sequencer for the 30-bit arithmetic unit: turns one command
// into a cycle-by-cycle train of one-hot unit strobes and reports completion.
module arith_seq #(
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    output logic             opnd_req,
    input  logic             opnd_ack,
    input  logic             reg_b0_to_ac,
    output logic             do_not_b_from_ac,
    output logic             do_sum_from_ac,
    output logic             do_and_from_ac,
    output logic             do_left_shift_b_from_ac,
    output logic             do_right_shift_bc_from_ac,
    output logic             do_move_c_to_a_from_ac,
    output logic             do_move_c_to_b_from_ac,
    output logic             do_move_b_to_c_from_ac,
    output logic             done,
    output logic             flag,
    output logic             err
);

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_SHL = 3'd3;
    localparam logic [2:0] OP_SHR = 3'd4;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_A,
        S_FETCH,
        S_LOAD_B,
        S_NEG_B,
        S_SUM,
        S_AND,
        S_SHIFT,
        S_WB,
        S_DONE
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flag_q, flag_d;
    logic             err_q, err_d;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    cnt_d  = cmd_count;
                    flag_d = 1'b0;
                    err_d  = 1'b0;
                    case (cmd_op)
                        OP_ADD, OP_SUB, OP_AND: state_d = S_LOAD_A;
                        OP_SHL:                 state_d = S_LOAD_B;
                        OP_SHR:                 state_d = (cmd_count == '0) ? S_DONE : S_SHIFT;
                        default: begin
                            err_d   = 1'b1;
                            state_d = S_DONE;
                        end
                    endcase
                end
            end
            S_LOAD_A: state_d = S_FETCH;
            S_FETCH: begin
                if (opnd_ack) begin
                    state_d = (op_q == OP_AND) ? S_AND : S_LOAD_B;
                end
            end
            S_LOAD_B: begin
                if (op_q == OP_SUB) begin
                    state_d = S_NEG_B;
                end else if (op_q == OP_SHL) begin
                    state_d = (cnt_q == '0) ? S_WB : S_SHIFT;
                end else begin
                    state_d = S_SUM;
                end
            end
            S_NEG_B: state_d = S_SUM;
            S_SUM:   state_d = S_WB;
            S_AND:   state_d = S_DONE;
            S_SHIFT: begin
                cnt_d = cnt_q - CNT_W'(1);
                // B0 holds the bit pushed out by the previous left shift
                if (op_q == OP_SHL) begin
                    flag_d = flag_q | reg_b0_to_ac;
                end
                if (cnt_q == CNT_W'(1)) begin
                    state_d = (op_q == OP_SHL) ? S_WB : S_DONE;
                end
            end
            S_WB: begin
                if (op_q == OP_ADD) begin
                    flag_d = reg_b0_to_ac;
                end else if (op_q == OP_SUB) begin
                    flag_d = ~reg_b0_to_ac;
                end else begin
                    flag_d = flag_q | reg_b0_to_ac;
                end
                state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            op_q    <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
            err_q   <= err_d;
        end
    end

    // Strobes are a pure decode of the state; the unit acts on them at the edge.
    assign cmd_ready                 = (state_q == S_IDLE);
    assign opnd_req                  = (state_q == S_FETCH);
    assign do_move_c_to_a_from_ac    = (state_q == S_LOAD_A);
    assign do_move_c_to_b_from_ac    = (state_q == S_LOAD_B);
    assign do_not_b_from_ac          = (state_q == S_NEG_B);
    assign do_sum_from_ac            = (state_q == S_SUM);
    assign do_and_from_ac            = (state_q == S_AND);
    assign do_left_shift_b_from_ac   = (state_q == S_SHIFT) && (op_q == OP_SHL);
    assign do_right_shift_bc_from_ac = (state_q == S_SHIFT) && (op_q != OP_SHL);
    assign do_move_b_to_c_from_ac    = (state_q == S_WB);
    assign done                      = (state_q == S_DONE);
    assign flag                      = done & flag_q;
    assign err                       = done & err_q;

endmodule

// File: tb/tb_arith_seq.sv
// Bench for arith_seq: a behavioural model of the arithmetic unit reacts to the
// strobes, and a scoreboard checks result, flag, err and done latency.
module tb_arith_seq;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd6;
    logic [4:0]  cmd_count = '0;
    logic        opnd_req;
    logic        opnd_ack = 1'b0;
    logic        reg_b0_to_ac;
    logic        do_not_b_from_ac, do_sum_from_ac, do_and_from_ac;
    logic        do_left_shift_b_from_ac, do_right_shift_bc_from_ac;
    logic        do_move_c_to_a_from_ac, do_move_c_to_b_from_ac, do_move_b_to_c_from_ac;
    logic        done, flag, err;

    always #5 clk = ~clk;

    arith_seq #(.CNT_W(5)) dut (
        .clk                       (clk),
        .reset                     (reset),
        .cmd_valid                 (cmd_valid),
        .cmd_ready                 (cmd_ready),
        .cmd_op                    (cmd_op),
        .cmd_count                 (cmd_count),
        .opnd_req                  (opnd_req),
        .opnd_ack                  (opnd_ack),
        .reg_b0_to_ac              (reg_b0_to_ac),
        .do_not_b_from_ac          (do_not_b_from_ac),
        .do_sum_from_ac            (do_sum_from_ac),
        .do_and_from_ac            (do_and_from_ac),
        .do_left_shift_b_from_ac   (do_left_shift_b_from_ac),
        .do_right_shift_bc_from_ac (do_right_shift_bc_from_ac),
        .do_move_c_to_a_from_ac    (do_move_c_to_a_from_ac),
        .do_move_c_to_b_from_ac    (do_move_c_to_b_from_ac),
        .do_move_b_to_c_from_ac    (do_move_b_to_c_from_ac),
        .done                      (done),
        .flag                      (flag),
        .err                       (err)
    );

    logic [7:0] strb;
    assign strb = {do_not_b_from_ac, do_sum_from_ac, do_and_from_ac,
                   do_left_shift_b_from_ac, do_right_shift_bc_from_ac,
                   do_move_c_to_a_from_ac, do_move_c_to_b_from_ac, do_move_b_to_c_from_ac};

    // Arithmetic unit model: B0 is the carry / shifted-out bit beside B.
    logic [29:0] ua = '0, ub = '0, uc = '0;
    logic        ub0 = 1'b0, ucin = 1'b0;
    logic        mdl_load = 1'b0;
    logic [29:0] mdl_c = '0;
    logic [29:0] opnd_data = '0;
    assign reg_b0_to_ac = ub0;

    always @(posedge clk) begin
        if (mdl_load) begin
            uc  <= mdl_c;
            ub  <= '0;
            ub0 <= 1'b0;
        end else begin
            if (opnd_ack)                  uc <= opnd_data;
            if (do_move_c_to_a_from_ac)    begin ua <= uc; ucin <= 1'b0; end
            if (do_move_c_to_b_from_ac)    begin ub <= uc; ub0 <= 1'b0; end
            if (do_not_b_from_ac)          begin ub <= ~ub; ucin <= 1'b1; end
            if (do_sum_from_ac)            {ub0, ub} <= {1'b0, ua} + {1'b0, ub} + 31'(ucin);
            if (do_and_from_ac)            uc <= ua & uc;
            if (do_left_shift_b_from_ac)   {ub0, ub} <= {ub, 1'b0};
            if (do_right_shift_bc_from_ac) {ub, uc} <= {1'b0, ub, uc[29:1]};
            if (do_move_b_to_c_from_ac)    uc <= ub;
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       tag;
        logic [29:0] c;
        logic        flag;
        logic        err;
        int          cyc;
    } exp_t;
    exp_t sb[$];

    int nchk = 0;
    int nerr = 0;
    int req_cycles = 0;
    bit mon_en = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp)
        else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic monitor();
        exp_t e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (opnd_req) req_cycles++;
                chk("onehot_strobes", 32'($countones(strb) <= 1), 32'd1);
                if (done) begin
                    chk("done_expected", 32'(sb.size() != 0), 32'd1);
                    if (sb.size() != 0) begin
                        e = sb.pop_front();
                        chk($sformatf("%s_c", e.tag), 32'(uc), 32'(e.c));
                        chk($sformatf("%s_flag", e.tag), 32'(flag), 32'(e.flag));
                        chk($sformatf("%s_err", e.tag), 32'(err), 32'(e.err));
                        chk($sformatf("%s_latency", e.tag), 32'(cyc - (e.cyc - 0)), 32'd0);
                    end
                end
            end
        end
    endtask

    task automatic do_cmd(input string tag, input logic [2:0] op, input logic [4:0] cnt,
                          input logic [29:0] c0, input logic [29:0] opnd, input int stall,
                          input bit busy, input logic [29:0] ec, input logic ef,
                          input logic ee, input int lat);
        exp_t e;
        int   k;
        @(negedge clk);
        mdl_c    = c0;
        mdl_load = 1'b1;
        @(negedge clk);
        mdl_load   = 1'b0;
        cmd_valid  = 1'b1;
        cmd_op     = op;
        cmd_count  = cnt;
        req_cycles = 0;
        e.tag = tag; e.c = ec; e.flag = ef; e.err = ee; e.cyc = cyc + lat;
        sb.push_back(e);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 3'd6;
        cmd_count = 5'($urandom);
        @(negedge clk);
        if (busy) begin
            cmd_valid = 1'b1;
            @(negedge clk);
            cmd_valid = 1'b0;
        end
        if (op <= 3'd2) begin
            k = 0;
            while (!opnd_req && k < 20) begin @(negedge clk); k++; end
            chk($sformatf("%s_fetch_seen", tag), 32'(opnd_req), 32'd1);
            for (int i = 0; i < stall; i++) @(negedge clk);
            opnd_data = opnd;
            opnd_ack  = 1'b1;
            @(posedge clk);
            #1;
            opnd_ack  = 1'b0;
            opnd_data = 30'($urandom);
            @(negedge clk);
        end
        k = 0;
        while (!done && k < 60) begin @(negedge clk); k++; end
        chk($sformatf("%s_done_seen", tag), 32'(done), 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int k;
        fork
            monitor();
        join_none

        // Reset held with a command offered: it must not be taken.
        cmd_valid = 1'b1;
        cmd_op    = 3'd6;
        repeat (3) @(negedge clk);
        mon_en = 1'b1;
        chk("rst_strobes", 32'(strb), 32'd0);
        chk("rst_opnd_req", 32'(opnd_req), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_flag", 32'(flag), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        do_cmd("add", 3'd0, 5'd0, 30'd5, 30'd7, 0, 1'b0, 30'd12, 1'b0, 1'b0, 6);
        chk("add_req_cycles", 32'(req_cycles), 32'd1);
        do_cmd("sub_neg", 3'd1, 5'd0, 30'd5, 30'd7, 0, 1'b0, 30'h3FFFFFFE, 1'b1, 1'b0, 7);
        do_cmd("sub_pos", 3'd1, 5'd0, 30'd9, 30'd4, 0, 1'b1, 30'd5, 1'b0, 1'b0, 7);
        do_cmd("and_stall", 3'd2, 5'd0, 30'h3F0F, 30'h0FF0, 3, 1'b0, 30'h0F00, 1'b0, 1'b0, 7);
        chk("and_req_cycles", 32'(req_cycles), 32'd4);
        do_cmd("shl3", 3'd3, 5'd3, 30'h08000001, 30'd0, 0, 1'b0, 30'h8, 1'b1, 1'b0, 6);
        do_cmd("shl0", 3'd3, 5'd0, 30'h08000001, 30'd0, 0, 1'b0, 30'h08000001, 1'b0, 1'b0, 3);
        do_cmd("shr4", 3'd4, 5'd4, 30'h100, 30'd0, 0, 1'b0, 30'h010, 1'b0, 1'b0, 5);
        do_cmd("illegal", 3'd6, 5'd9, 30'h1234, 30'd0, 0, 1'b0, 30'h1234, 1'b0, 1'b1, 1);
        do_cmd("shl31", 3'd3, 5'd31, 30'h3FFFFFFF, 30'd0, 0, 1'b0, 30'd0, 1'b1, 1'b0, 34);
        do_cmd("add_carry", 3'd0, 5'd0, 30'h3FFFFFFF, 30'd1, 0, 1'b0, 30'd0, 1'b1, 1'b0, 6);

        // Reset pulsed while an ADD sits in SUM: no completion may follow.
        @(negedge clk);
        mdl_c    = 30'd5;
        mdl_load = 1'b1;
        @(negedge clk);
        mdl_load  = 1'b0;
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        @(negedge clk);
        k = 0;
        while (!opnd_req && k < 20) begin @(negedge clk); k++; end
        opnd_data = 30'd7;
        opnd_ack  = 1'b1;
        @(posedge clk);
        #1;
        opnd_ack = 1'b0;
        @(negedge clk);
        k = 0;
        while (!do_sum_from_ac && k < 10) begin @(negedge clk); k++; end
        chk("midrst_sum_seen", 32'(do_sum_from_ac), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_strobes", 32'(strb), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_req", 32'(opnd_req), 32'd0);
        repeat (3) @(negedge clk);
        chk("midrst_still_idle", 32'(cmd_ready), 32'd1);

        do_cmd("add_after_rst", 3'd0, 5'd0, 30'd5, 30'd7, 0, 1'b0, 30'd12, 1'b0, 1'b0, 6);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

endmodule
